// File: rtl/icache_axi_pkg.sv
// Shared constants for the instruction-fetch burst read responder.
package icache_axi_pkg;

  // FSM state encoding
  localparam logic IDLE = 1'b0;
  localparam logic DATA = 1'b1;

  // Burst lengths the fetch unit issues (beats minus one)
  localparam logic [7:0] ARLEN_UNCACHE = 8'd1;
  localparam logic [7:0] ARLEN_LINE    = 8'd3;

endpackage

// File: rtl/inst_word_mem.sv
// Word-addressed instruction memory: combinational read, synchronous backdoor write.
// A write and a read of the same word in one cycle return the old data.
module inst_word_mem #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  // Backdoor preload/patch write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icache_axi_rd_responder.sv
// AXI-style burst read responder for the instruction-fetch channel.
// Accepts one request, returns arlen+1 beats from the internal memory under rready.
//
// state | meaning
// IDLE  | arready high (from the first edge after reset), waiting for a request
// DATA  | beats being returned; arready low, arvalid ignored
module icache_axi_rd_responder
  import icache_axi_pkg::*;
#(
  parameter int MEM_AW    = 14,
  parameter int MAX_ARLEN = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arvalid,
  input  logic [31:0]       i_araddr,
  input  logic [7:0]        i_arlen,
  output logic              i_arready,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  output logic              i_rlast,
  input  logic              i_rready,
  input  logic              init_we,
  input  logic [MEM_AW-1:0] init_addr,
  input  logic [31:0]       init_data
);

  logic              r_state, w_state_nxt;
  logic [MEM_AW-1:0] r_idx, w_idx_nxt, w_rd_idx;
  logic [7:0]        r_len, w_len_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_arready, w_arready_nxt;
  logic              r_rvalid, w_rvalid_nxt;
  logic              r_rlast, w_rlast_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic [31:0]       w_mem_rdata;
  logic              w_ar_hs, w_r_hs, w_last_hs;
  logic              w_unused_addr;

  assign w_ar_hs   = (r_state == IDLE) & r_arready & i_arvalid;
  assign w_r_hs    = r_rvalid & i_rready;
  assign w_last_hs = w_r_hs & (r_cnt == r_len);

  // In IDLE the memory looks up the requested word; in DATA it looks ahead one word
  assign w_rd_idx = (r_state == IDLE) ? i_araddr[MEM_AW+1:2] : r_idx + 1'b1;

  assign w_unused_addr = ^{i_araddr[31:MEM_AW+2], i_araddr[1:0]};

  inst_word_mem #(.AW(MEM_AW)) u_mem (
    .clk     (clk),
    .i_we    (init_we),
    .i_waddr (init_addr),
    .i_wdata (init_data),
    .i_raddr (w_rd_idx),
    .o_rdata (w_mem_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ar_hs)   w_state_nxt = DATA;
      DATA:    if (w_last_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values for the beat counter, address and registered channel outputs
  always_comb begin
    w_idx_nxt     = r_idx;
    w_len_nxt     = r_len;
    w_cnt_nxt     = r_cnt;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rlast_nxt   = r_rlast;
    w_rdata_nxt   = r_rdata;
    case (r_state)
      IDLE: begin
        if (w_ar_hs) begin
          w_idx_nxt     = w_rd_idx;
          w_len_nxt     = i_arlen;
          w_cnt_nxt     = 8'd0;
          w_rdata_nxt   = w_mem_rdata;
          w_rvalid_nxt  = 1'b1;
          w_rlast_nxt   = (i_arlen == 8'd0);
          w_arready_nxt = 1'b0;
        end else begin
          w_arready_nxt = 1'b1;
        end
      end
      DATA: begin
        if (w_r_hs) begin
          if (r_cnt != r_len) begin
            w_cnt_nxt   = r_cnt + 8'd1;
            w_idx_nxt   = w_rd_idx;
            w_rdata_nxt = w_mem_rdata;
            w_rlast_nxt = ((r_cnt + 8'd1) == r_len);
          end else begin
            w_rvalid_nxt  = 1'b0;
            w_rlast_nxt   = 1'b0;
            w_arready_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_len     <= 8'd0;
      r_cnt     <= 8'd0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_len     <= w_len_nxt;
      r_cnt     <= w_cnt_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  // Protocol sanity: legal burst length, counter never passes len, rlast only with rvalid
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_ar_hs) assert ({24'd0, i_arlen} <= 32'(MAX_ARLEN));
      if (r_state == DATA) assert (r_cnt <= r_len);
      assert (!r_rlast || r_rvalid);
    end
  end

  assign i_arready = r_arready;
  assign i_rdata   = r_rdata;
  assign i_rvalid  = r_rvalid;
  assign i_rlast   = r_rlast;

endmodule

// File: tb/tb_icache_axi_rd_responder.sv
// Bench for the burst read responder: table of bursts plus directed corner sequences,
// beats checked against a queue of expected {data, last} filled when requests are driven.
module tb_icache_axi_rd_responder;
  import icache_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, rready, init_we;
  logic [31:0] araddr, init_data;
  logic [7:0]  arlen;
  logic [13:0] init_addr;
  logic        arready, rvalid, rlast;
  logic [31:0] rdata;

  logic        s_arvalid, s_rready, s_init_we;
  logic [31:0] s_araddr, s_init_data;
  logic [7:0]  s_arlen;
  logic [3:0]  s_init_addr;
  logic        s_arready, s_rvalid, s_rlast;
  logic [31:0] s_rdata;

  always #5 clk = ~clk;

  icache_axi_rd_responder #(.MEM_AW(14), .MAX_ARLEN(255)) dut (
    .clk(clk), .rst(rst),
    .i_arvalid(arvalid), .i_araddr(araddr), .i_arlen(arlen), .i_arready(arready),
    .i_rdata(rdata), .i_rvalid(rvalid), .i_rlast(rlast), .i_rready(rready),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  icache_axi_rd_responder #(.MEM_AW(4), .MAX_ARLEN(255)) dut_small (
    .clk(clk), .rst(rst),
    .i_arvalid(s_arvalid), .i_araddr(s_araddr), .i_arlen(s_arlen), .i_arready(s_arready),
    .i_rdata(s_rdata), .i_rvalid(s_rvalid), .i_rlast(s_rlast), .i_rready(s_rready),
    .init_we(s_init_we), .init_addr(s_init_addr), .init_data(s_init_data)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [15:0] mask;
    logic [31:0] exp_first;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [16384];
  vec_t        vecs [7];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [7:0] len);
    exp_t        e;
    logic [13:0] idx;
    idx = addr[15:2];
    for (int k = 0; k <= int'(len); k++) begin
      e.data = mdl[idx];
      e.last = (k == int'(len));
      exp_q.push_back(e);
      idx = idx + 14'd1;
    end
  endtask

  // Drive a request, wait for acceptance, return in the cycle after the accepting edge.
  task automatic start_burst(input logic [31:0] addr, input logic [7:0] len);
    logic acc;
    arvalid = 1'b1;
    araddr  = addr;
    arlen   = len;
    push_exp(addr, len);
    acc = 1'b0;
    for (int j = 0; j < 20 && !acc; j++) begin
      acc = arready;
      tick();
    end
    arvalid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    chk("first_beat_valid", 32'(rvalid), 32'd1);
  endtask

  // Run beats with the given rready pattern until the rlast handshake.
  task automatic finish_burst(input logic [15:0] mask, output int cycles);
    logic done;
    done   = 1'b0;
    cycles = 0;
    for (int j = 0; j < 600 && !done; j++) begin
      rready = (j < 16) ? mask[j] : 1'b1;
      done   = rvalid && rready && rlast;
      tick();
      cycles++;
    end
    rready = 1'b1;
    if (!done) chk("burst_timeout", 32'd0, 32'd1);
    chk("post_rvalid", 32'(rvalid), 32'd0);
    chk("post_arready", 32'(arready), 32'd1);
  endtask

  // Scoreboard: every valid cycle (stalls included) must show the head beat
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("sb_rdata", rdata, exp_q[0].data);
        chk("sb_rlast", 32'(rlast), 32'(exp_q[0].last));
        if (rready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int          cyc;
    logic [31:0] old5;

    rst = 1'b1;
    arvalid = 0; araddr = 0; arlen = 0; rready = 1; init_we = 0; init_addr = 0; init_data = 0;
    s_arvalid = 0; s_araddr = 0; s_arlen = 0; s_rready = 1; s_init_we = 0; s_init_addr = 0; s_init_data = 0;

    vecs[0] = '{32'h0000_0400, ARLEN_LINE,    16'hFFFF, 32'h0000_00A0};
    vecs[1] = '{32'h0000_0404, ARLEN_UNCACHE, 16'hFFF9, 32'h0000_00A1};
    vecs[2] = '{32'h0000_0408, 8'd0,          16'hFFFF, 32'h0000_00A2};
    vecs[3] = '{32'h0000_040C, 8'd7,          16'h5555, 32'h0000_00A3};
    vecs[4] = '{32'h1234_0401, 8'd1,          16'h3333, 32'h0000_00A0};
    vecs[5] = '{32'h0000_FFF8, 8'd3,          16'hFFFF, 32'hC0DE_3FFE};
    vecs[6] = '{32'h0000_0800, 8'd255,        16'hFFFF, 32'hC0DE_0200};

    #23;
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rel_arready_low", 32'(arready), 32'd0);
    tick();
    chk("rel_arready_high", 32'(arready), 32'd1);

    // Small memory: start at the last word and wrap to word 0
    for (int i = 0; i < 16; i++) begin
      s_init_we = 1'b1; s_init_addr = 4'(i); s_init_data = 32'h0000_00B0 + 32'(i);
      tick();
    end
    s_init_we = 1'b0;
    s_arvalid = 1'b1; s_araddr = 32'h0000_003C; s_arlen = ARLEN_LINE;
    chk("wrap_arready", 32'(s_arready), 32'd1);
    tick();
    s_arvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_rvalid", 32'(s_rvalid), 32'd1);
      chk("wrap_rdata", s_rdata, 32'h0000_00B0 + 32'((15 + k) % 16));
      chk("wrap_rlast", 32'(s_rlast), 32'(k == 3));
      tick();
    end
    chk("wrap_done", 32'(s_rvalid), 32'd0);

    // Preload the full main memory and the model
    for (int i = 0; i < 16384; i++) begin
      init_we   = 1'b1;
      init_addr = 14'(i);
      init_data = (i >= 32'h100 && i < 32'h110) ? 32'h0000_00A0 + 32'(i - 32'h100)
                                               : {16'hC0DE, 16'(i)};
      mdl[i]    = init_data;
      tick();
    end
    init_we = 1'b0;

    // Table of bursts
    for (int v = 0; v < 7; v++) begin
      start_burst(vecs[v].addr, vecs[v].len);
      chk("vec_first_rdata", rdata, vecs[v].exp_first);
      finish_burst(vecs[v].mask, cyc);
      if (vecs[v].mask == 16'hFFFF) chk("vec_no_bubble", 32'(cyc), 32'(vecs[v].len) + 32'd1);
      tick();
    end

    // Request presented on the final beat waits one idle cycle
    start_burst(32'h0000_0400, ARLEN_UNCACHE);
    tick();
    chk("b2b_final_arready", 32'(arready), 32'd0);
    arvalid = 1'b1; araddr = 32'h0000_0408; arlen = 8'd0;
    push_exp(32'h0000_0408, 8'd0);
    tick();
    chk("b2b_not_taken", 32'(rvalid), 32'd0);
    chk("b2b_idle_arready", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    chk("b2b_first_valid", 32'(rvalid), 32'd1);
    chk("b2b_first_rdata", rdata, 32'h0000_00A2);
    finish_burst(16'hFFFF, cyc);
    tick();

    // Reset during the second beat of a line refill
    start_burst(32'h0000_0400, ARLEN_LINE);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_rlast", 32'(rlast), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rel_arready_low", 32'(arready), 32'd0);
    tick();
    chk("mid_rel_arready_high", 32'(arready), 32'd1);
    start_burst(32'h0000_0404, ARLEN_UNCACHE);
    chk("mid_fresh_rdata", rdata, 32'h0000_00A1);
    finish_burst(16'hFFFF, cyc);
    tick();

    // Backdoor write to the word being loaded returns old data
    old5 = mdl[5];
    start_burst(32'h0000_0010, ARLEN_UNCACHE);
    rready = 1'b1;
    init_we = 1'b1; init_addr = 14'd5; init_data = 32'h0000_DEAD;
    tick();
    init_we = 1'b0;
    mdl[5] = 32'h0000_DEAD;
    chk("rbw_old_data", rdata, old5);
    finish_burst(16'hFFFF, cyc);
    tick();
    start_burst(32'h0000_0014, 8'd0);
    chk("rbw_new_data", rdata, 32'h0000_DEAD);
    finish_burst(16'hFFFF, cyc);
    tick();

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
